// File: rtl/path_backtrace_pkg.sv
// Shared pathfinding types for the backtrace block: explored-RAM node record,
// sizing defaults and FSM state encoding.
package path_backtrace_pkg;

    localparam int DEF_MAX_NODES = 100;
    localparam int DEF_MAX_PATH  = 32;
    localparam int ADDR_W        = 7;
    localparam int ID_W          = 16;
    localparam int ENTRY_W       = 48;

    typedef struct packed {
        logic [15:0] node_id;
        logic [15:0] parent_node_id;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] current_cost;
    } node_info;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SCAN_SET   = 3'd1,
        ST_SCAN_WAIT  = 3'd2,
        ST_SCAN_CHECK = 3'd3,
        ST_PUSH       = 3'd4,
        ST_EMIT       = 3'd5,
        ST_DONE       = 3'd6,
        ST_ERROR      = 3'd7
    } bt_state_e;

    // Stack entry layout: {node_id, x, y}
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [15:0] id,
                                                      input logic [15:0] px,
                                                      input logic [15:0] py);
        return {id, px, py};
    endfunction

endpackage

// File: rtl/path_backtrace_if.sv
// Request, explored-RAM read port and path read-out signals of path_backtrace.
interface path_backtrace_if;
    import path_backtrace_pkg::*;

    logic                start;
    logic [ID_W-1:0]     goal_id;
    logic [ID_W-1:0]     start_id;
    logic [ADDR_W-1:0]   ram_read_address;
    node_info            ram_read_node;
    logic                busy;
    logic                path_valid;
    logic                path_ready;
    logic [ID_W-1:0]     path_node_id;
    logic [ID_W-1:0]     path_x;
    logic [ID_W-1:0]     path_y;
    logic [ADDR_W-1:0]   path_len;
    logic                done;
    logic                error;

    modport master (
        output start, goal_id, start_id, ram_read_node, path_ready,
        input  ram_read_address, busy, path_valid, path_node_id, path_x, path_y,
               path_len, done, error
    );

    modport slave (
        input  start, goal_id, start_id, ram_read_node, path_ready,
        output ram_read_address, busy, path_valid, path_node_id, path_x, path_y,
               path_len, done, error
    );

endinterface

// File: rtl/path_backtrace_stack.sv
// path_stack: LIFO of {node_id,x,y} entries; count updates on the push/pop edge,
// top entry is read straight from the register file.
module path_stack #(
    parameter int DEPTH = 32,
    parameter int W     = 48,
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     data_i,
    output logic [W-1:0]     top_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] top_idx_s;

    assign empty_o = (count_q == CNT_W'(0));
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

    // Occupancy counter; clear wins over push/pop
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            count_q <= CNT_W'(0);
        end else if (push_i && !full_o) begin
            count_q <= count_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            count_q <= count_q - CNT_W'(1);
        end else begin
            count_q <= count_q;
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_i && !full_o && !clear_i && !reset) begin
            mem_q[count_q[IDX_W-1:0]] <= data_i;
        end
    end

    // Top-of-stack read, zero when empty
    always_comb begin
        top_idx_s = IDX_W'(count_q - CNT_W'(1));
        if (empty_o) begin
            top_o = '0;
        end else begin
            top_o = mem_q[top_idx_s];
        end
    end

endmodule

// File: rtl/path_backtrace.sv
// Walks parent links in the explored RAM from goal back to start, stacking each
// node, then streams the path start-first. Define BACKTRACE_COST_CHECK_EN to
// reject parents whose cost does not strictly decrease.
module path_backtrace
    import path_backtrace_pkg::*;
#(
    parameter int MAX_NODES = DEF_MAX_NODES,
    parameter int MAX_PATH  = DEF_MAX_PATH
) (
    input  logic          clk,
    input  logic          reset,
    path_backtrace_if.slave bt
);

    localparam int CNT_W = $clog2(MAX_PATH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_NODES - 1);

    bt_state_e          state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ID_W-1:0]    target_q;
    logic [ID_W-1:0]    start_id_q;
    logic [ID_W-1:0]    cur_id_q;
    logic [ID_W-1:0]    cur_parent_q;
    logic [ID_W-1:0]    cur_x_q;
    logic [ID_W-1:0]    cur_y_q;
    logic [ADDR_W-1:0]  path_len_q;
    logic               busy_q;
    logic               path_valid_q;
    logic               done_q;
    logic               error_q;
    logic               cost_fail_s;

    logic               stk_clear_s;
    logic               stk_push_s;
    logic               stk_pop_s;
    logic [ENTRY_W-1:0] stk_top_s;
    logic               stk_empty_s;
    logic               stk_full_s;
    logic [CNT_W-1:0]   stk_count_s;

    assign stk_clear_s = (state_q == ST_IDLE) && bt.start;
    assign stk_push_s  = (state_q == ST_PUSH);
    assign stk_pop_s   = (state_q == ST_EMIT) && path_valid_q && bt.path_ready;

    path_stack #(.DEPTH(MAX_PATH), .W(ENTRY_W)) u_stack (
        .clk     (clk),
        .reset   (reset),
        .clear_i (stk_clear_s),
        .push_i  (stk_push_s),
        .pop_i   (stk_pop_s),
        .data_i  (pack_entry(cur_id_q, cur_x_q, cur_y_q)),
        .top_o   (stk_top_s),
        .empty_o (stk_empty_s),
        .full_o  (stk_full_s),
        .count_o (stk_count_s)
    );

`ifdef BACKTRACE_COST_CHECK_EN
    logic [ID_W-1:0] cur_cost_q;
    logic [ID_W-1:0] prev_cost_q;

    // Cost history for the monotonic-cost guard
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_cost_q  <= 16'd0;
            prev_cost_q <= 16'd0;
        end else if (state_q == ST_SCAN_CHECK) begin
            cur_cost_q  <= bt.ram_read_node.current_cost;
        end else if (state_q == ST_PUSH) begin
            prev_cost_q <= cur_cost_q;
        end else begin
            cur_cost_q  <= cur_cost_q;
        end
    end

    // A parent must be strictly cheaper than the child pushed before it
    always_comb begin
        cost_fail_s = 1'b0;
        if ((path_len_q != 7'd0) && (cur_cost_q >= prev_cost_q)) begin
            cost_fail_s = 1'b1;
        end else begin
            cost_fail_s = 1'b0;
        end
    end
`else
    assign cost_fail_s = 1'b0;
`endif

    // Backtrace controller with registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= 7'd0;
            target_q     <= 16'd0;
            start_id_q   <= 16'd0;
            cur_id_q     <= 16'd0;
            cur_parent_q <= 16'd0;
            cur_x_q      <= 16'd0;
            cur_y_q      <= 16'd0;
            path_len_q   <= 7'd0;
            busy_q       <= 1'b0;
            path_valid_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bt.start) begin
                        target_q   <= bt.goal_id;
                        start_id_q <= bt.start_id;
                        path_len_q <= 7'd0;
                        addr_q     <= 7'd0;
                        busy_q     <= 1'b1;
                        if (bt.goal_id == 16'd0) begin
                            done_q  <= 1'b1;
                            error_q <= 1'b1;
                            state_q <= ST_ERROR;
                        end else begin
                            error_q <= 1'b0;
                            state_q <= ST_SCAN_SET;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SCAN_SET:  state_q <= ST_SCAN_WAIT;
                ST_SCAN_WAIT: state_q <= ST_SCAN_CHECK;
                ST_SCAN_CHECK: begin
                    // An empty slot ends the explored region, even when chasing id 0
                    if (bt.ram_read_node.node_id == 16'd0) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= ST_ERROR;
                    end else if (bt.ram_read_node.node_id == target_q) begin
                        cur_id_q     <= bt.ram_read_node.node_id;
                        cur_parent_q <= bt.ram_read_node.parent_node_id;
                        cur_x_q      <= bt.ram_read_node.x;
                        cur_y_q      <= bt.ram_read_node.y;
                        state_q      <= ST_PUSH;
                    end else if (addr_q == LAST_ADDR) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= ST_ERROR;
                    end else begin
                        addr_q  <= addr_q + 7'd1;
                        state_q <= ST_SCAN_SET;
                    end
                end
                ST_PUSH: begin
                    path_len_q <= path_len_q + 7'd1;
                    if (cur_id_q == start_id_q) begin
                        path_valid_q <= 1'b1;
                        state_q      <= ST_EMIT;
                    end else if (cost_fail_s ||
                                 (stk_count_s == CNT_W'(MAX_PATH - 1))) begin
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= ST_ERROR;
                    end else begin
                        target_q <= cur_parent_q;
                        addr_q   <= 7'd0;
                        state_q  <= ST_SCAN_SET;
                    end
                end
                ST_EMIT: begin
                    if (stk_pop_s && (stk_count_s == CNT_W'(1))) begin
                        path_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        state_q <= ST_EMIT;
                    end
                end
                ST_DONE, ST_ERROR: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q       <= 1'b0;
                    path_valid_q <= 1'b0;
                    done_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    // Path data is forced to zero outside the read-out window
    always_comb begin
        if (path_valid_q) begin
            bt.path_node_id = stk_top_s[47:32];
            bt.path_x       = stk_top_s[31:16];
            bt.path_y       = stk_top_s[15:0];
        end else begin
            bt.path_node_id = 16'd0;
            bt.path_x       = 16'd0;
            bt.path_y       = 16'd0;
        end
    end

    assign bt.ram_read_address = addr_q;
    assign bt.busy             = busy_q;
    assign bt.path_valid       = path_valid_q;
    assign bt.path_len         = path_len_q;
    assign bt.done             = done_q;
    assign bt.error            = error_q;

endmodule

// File: tb/tb_path_backtrace.sv
// Directed bench for path_backtrace: small explored-RAM images with a 2-cycle
// read model, hand-computed paths, error cases and mid-run resets.
module tb_path_backtrace;
    import path_backtrace_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    path_backtrace_if bt();

    path_backtrace #(.MAX_NODES(100), .MAX_PATH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bt    (bt)
    );

    node_info ram_m [0:127];
    node_info rd1_r, rd2_r;

    // Explored RAM with two cycles of read latency
    always @(posedge clk) begin
        rd1_r <= ram_m[bt.ram_read_address];
        rd2_r <= rd1_r;
    end
    assign bt.ram_read_node = rd2_r;

    int n_checks = 0;
    int n_fails  = 0;
    int exp_q[$];
    logic [6:0] last_addr;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic node_info mk(input int id, input int parent, input int cost);
        node_info n;
        n.node_id        = 16'(id);
        n.parent_node_id = 16'(parent);
        n.x              = 16'(id + 1000);
        n.y              = 16'(id + 2000);
        n.current_cost   = 16'(cost);
        return n;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) ram_m[i] = '0;
    endtask

    // One backtrace run: checks emitted ids/coords, path_len, error and done pulse
    task automatic run_bt(input string tag, input int goal, input int sid,
                          input bit toggle, input bit spurious,
                          input int exp_len, input bit exp_err);
        int got_q[$];
        int cyc;
        bit seen_done;
        logic err_d;
        logic [6:0] len_d;
        got_q = {};
        seen_done = 1'b0;
        err_d = 1'b0;
        len_d = 7'd0;
        cyc = 0;
        bt.goal_id    = 16'(goal);
        bt.start_id   = 16'(sid);
        bt.path_ready = toggle ? 1'b0 : 1'b1;
        bt.start      = 1'b1;
        @(posedge clk); #1;
        while (!seen_done && cyc < 20000) begin
            if (spurious && cyc == 3) begin
                bt.start    = 1'b1;
                bt.goal_id  = 16'd2;
                bt.start_id = 16'd2;
            end else begin
                bt.start = 1'b0;
            end
            if (toggle) bt.path_ready = ~bt.path_ready;
            if (bt.path_valid && bt.path_ready) begin
                got_q.push_back(int'(bt.path_node_id));
                check_eq({tag, "/x"}, bt.path_x, 32'(bt.path_node_id) + 32'd1000);
                check_eq({tag, "/y"}, bt.path_y, 32'(bt.path_node_id) + 32'd2000);
            end
            if (bt.done) begin
                seen_done = 1'b1;
                err_d     = bt.error;
                len_d     = bt.path_len;
                last_addr = bt.ram_read_address;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bt.start = 1'b0;
        check_eq({tag, "/done_seen"}, 32'(seen_done), 32'd1);
        check_eq({tag, "/error"}, 32'(err_d), 32'(exp_err));
        check_eq({tag, "/path_len"}, 32'(len_d), 32'(exp_len));
        check_eq({tag, "/n_emitted"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq({tag, "/entry"}, 32'(got_q[i]), 32'(exp_q[i]));
        check_eq({tag, "/done_pulse"}, 32'(bt.done), 32'd0);
        check_eq({tag, "/busy_after"}, 32'(bt.busy), 32'd0);
        check_eq({tag, "/error_held"}, 32'(bt.error), 32'(exp_err));
        check_eq({tag, "/id_idle"}, 32'(bt.path_node_id), 32'd0);
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        bt.start = 1'b0;
        bt.goal_id = 16'd0;
        bt.start_id = 16'd0;
        bt.path_ready = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst/busy", 32'(bt.busy), 32'd0);
        check_eq("rst/valid", 32'(bt.path_valid), 32'd0);
        check_eq("rst/done", 32'(bt.done), 32'd0);
        check_eq("rst/error", 32'(bt.error), 32'd0);
        check_eq("rst/addr", 32'(bt.ram_read_address), 32'd0);
        check_eq("rst/len", 32'(bt.path_len), 32'd0);
        check_eq("rst/id", 32'(bt.path_node_id), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic 3-node chain, with an ignored start mid-scan
        ram_m[0] = mk(1, 0, 1);
        ram_m[1] = mk(2, 1, 2);
        ram_m[2] = mk(3, 2, 3);
        exp_q = '{1, 2, 3};
        run_bt("chain3", 3, 1, 1'b0, 1'b1, 3, 1'b0);

        exp_q = {};
        run_bt("absent", 9, 1, 1'b0, 1'b0, 0, 1'b1);
        check_eq("absent/stop_addr", 32'(last_addr), 32'd3);

        exp_q = '{2};
        run_bt("single", 2, 2, 1'b0, 1'b0, 1, 1'b0);

        exp_q = {};
        run_bt("goal0", 0, 1, 1'b0, 1'b0, 0, 1'b1);

        exp_q = '{1, 2, 3};
        run_bt("toggle", 3, 1, 1'b1, 1'b0, 3, 1'b0);

        // 40-node chain overflows a 32-entry stack
        clear_mem();
        for (int i = 0; i < 40; i++) ram_m[i] = mk(i + 1, i, i + 1);
        exp_q = {};
        run_bt("chain40", 40, 1, 1'b0, 1'b0, 32, 1'b1);

        // 2<->3 parent loop with equal costs
        clear_mem();
        ram_m[0] = mk(2, 3, 5);
        ram_m[1] = mk(3, 2, 5);
        exp_q = {};
`ifdef BACKTRACE_COST_CHECK_EN
        run_bt("loop", 3, 1, 1'b0, 1'b0, 2, 1'b1);
`else
        run_bt("loop", 3, 1, 1'b0, 1'b0, 32, 1'b1);
`endif

        // Full-depth scan: match at the last address, then miss at it
        clear_mem();
        for (int i = 0; i < 100; i++) ram_m[i] = mk(500 + i, 0, 1);
        exp_q = '{599};
        run_bt("last_hit", 599, 599, 1'b0, 1'b0, 1, 1'b0);
        exp_q = {};
        run_bt("last_miss", 700, 1, 1'b0, 1'b0, 0, 1'b1);
        check_eq("last_miss/stop_addr", 32'(last_addr), 32'd99);

        // Reset while in SCAN_WAIT
        clear_mem();
        ram_m[0] = mk(1, 0, 1);
        ram_m[1] = mk(2, 1, 2);
        ram_m[2] = mk(3, 2, 3);
        bt.goal_id = 16'd3;
        bt.start_id = 16'd1;
        bt.start = 1'b1;
        @(posedge clk); #1;
        bt.start = 1'b0;
        @(posedge clk); #1;
        check_eq("rst_scan/busy_before", 32'(bt.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("rst_scan/busy", 32'(bt.busy), 32'd0);
        check_eq("rst_scan/addr", 32'(bt.ram_read_address), 32'd0);

        // Reset during EMIT while path_ready holds the stream
        bt.path_ready = 1'b0;
        bt.start = 1'b1;
        @(posedge clk); #1;
        bt.start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (bt.path_valid) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check_eq("rst_emit/valid_seen", 32'(found), 32'd1);
        check_eq("rst_emit/top_id", 32'(bt.path_node_id), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("rst_emit/valid", 32'(bt.path_valid), 32'd0);
        check_eq("rst_emit/id", 32'(bt.path_node_id), 32'd0);
        check_eq("rst_emit/len", 32'(bt.path_len), 32'd0);
        check_eq("rst_emit/busy", 32'(bt.busy), 32'd0);

        exp_q = '{1, 2, 3};
        run_bt("after_rst", 3, 1, 1'b0, 1'b0, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/path_backtrace.md
PATH_BACKTRACE -- requirements
Module: path_backtrace

Interface
REQ-001 Parameter MAX_NODES, default 100, explored-RAM depth scanned (addresses 0..MAX_NODES-1).
REQ-002 Parameter MAX_PATH, default 32, path stack depth in nodes.
REQ-003 clk  input  1  clock; all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin backtrace; honoured only in IDLE.
REQ-006 goal_id  input  16  node_id where the backtrace begins; sampled when start is accepted.
REQ-007 start_id  input  16  node_id of the path origin; sampled when start is accepted.
REQ-008 ram_read_address  output  7  registered read address to explored RAM.
REQ-009 ram_read_node  input  node_info  explored-RAM read data, valid two cycles after ram_read_address changes.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 path_valid / path_ready  output / input  1 / 1  path read-out handshake.
REQ-012 path_node_id, path_x, path_y  output  16 each  current path entry, valid while path_valid is high.
REQ-013 path_len  output  7  number of nodes pushed in the current or last run.
REQ-014 done  output  1  one-cycle pulse at run completion (success or error).
REQ-015 error  output  1  set with done on failure; held until the next accepted start or reset.

Function
REQ-016 States: IDLE, SCAN_SET, SCAN_WAIT, SCAN_CHECK, PUSH, EMIT, DONE, ERROR.
REQ-017 IDLE: on start, latch target=goal_id and start_id, clear stack, path_len=0, error=0, address=0, go to SCAN_SET.
REQ-018 If goal_id==0 at start, go to ERROR directly.
REQ-019 SCAN_SET→SCAN_WAIT→SCAN_CHECK; SCAN_CHECK compares ram_read_node.node_id with target.
REQ-020 SCAN_CHECK outcomes: match→PUSH; node_id==0, or address==MAX_NODES-1 without a match→ERROR (target not found); otherwise increment address and go to SCAN_SET.
REQ-021 PUSH: store {node_id,x,y} at the top of the stack and increment path_len; if node_id==start_id go to EMIT; if the stack is now full go to ERROR; otherwise set target=parent_node_id, reset address to 0, and go to SCAN_SET.
REQ-022 EMIT: path_valid=1 while the stack is non-empty and presents the top entry, so the start node comes out first and the goal node last.
REQ-023 A pop occurs on the same edge where path_valid&&path_ready; when the last entry pops, go to DONE.
REQ-024 DONE: done=1 for one cycle, then IDLE; ERROR: done=1 and error=1 for one cycle, then IDLE with error held.
REQ-025 start outside IDLE is ignored, with no state change.
REQ-026 If goal_id==start_id, the path has length 1 and a single entry is emitted.
REQ-027 Worst-case scan latency per hop is 3*MAX_NODES cycles.

Reset
REQ-028 Reset forces IDLE, ram_read_address=0, stack empty, path_len=0, and busy, path_valid, done and error all 0, in any state including mid-scan or mid-EMIT.
REQ-029 path_node_id, path_x and path_y read 0 while path_valid is 0.

Configuration
REQ-030 BACKTRACE_COST_CHECK_EN defined: in PUSH, a non-start parent whose current_cost is not strictly less than the previously pushed node's current_cost is a cycle or corruption and goes to ERROR.
REQ-031 BACKTRACE_COST_CHECK_EN undefined: no cost comparison; the stack-full check alone bounds runaway loops.

Structure
REQ-032 node_info typedef, the MAX_NODES/MAX_PATH defaults and state encodings live in a shared pathfinding package; node_info is no longer declared per file.
REQ-033 One sub-module, path_stack: a LIFO of MAX_PATH x 48-bit entries with push, pop, clear, empty, full and count, using one-cycle registered pop.

Verification
REQ-034 RAM holds ids 1(parent 0),2(parent 1),3(parent 2), then 0; start with goal=3, start=1, path_ready=1 → emits 1,2,3, path_len=3, done pulse, error=0.
REQ-035 goal=9, not present in RAM → error=1 after the scan hits the node_id==0 slot, with no path_valid.
REQ-036 goal=start=2 → single entry id 2, path_len=1.
REQ-037 Chain of 40 nodes with MAX_PATH=32 → error when the 32nd entry is pushed.
REQ-038 path_ready toggled 1/0 every cycle during EMIT → each entry appears exactly once and in order; reset asserted mid-SCAN_WAIT → IDLE next cycle, busy=0.
REQ-039 With BACKTRACE_COST_CHECK_EN, 2↔3 parent loop with equal costs → error on the second push.
